// File: rtl/riscv_arb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_arb_pkg
// Shared types and constants for the dual-core data-memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   NCORES      : number of requesting cores (two LSUs)
//   core_id_t   : one-bit core identifier
// No ports (package).
// ---------------------------------------------------------------------------
package riscv_arb_pkg;

  localparam int NCORES = 2;

  typedef logic [0:0] core_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
// Round-robin selector for the two cores. It owns the "last served" pointer,
// which resets to core 1 so that core 0 wins the first contention.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid_i  : per-core request valid
//   hold_i       : stick with the last served core (bus lock in force)
//   done_i       : completion pulse; loads the pointer with done_id_i
//   done_id_i    : core whose transaction just completed
//   sel_id_o     : core that would be granted this cycle
//   sel_valid_o  : sel_id_o refers to a core that is actually requesting
// ---------------------------------------------------------------------------
module arb_rr_pick
  import riscv_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NCORES-1:0] req_valid_i,
  input  logic              hold_i,
  input  logic              done_i,
  input  core_id_t          done_id_i,
  output core_id_t          sel_id_o,
  output logic              sel_valid_o
);

  core_id_t last_q;

  // Selection: while held, only the last served core may go. Otherwise a
  // lone requester wins outright, and under contention the core that was
  // not served last takes its turn.
  always_comb begin
    sel_id_o    = '0;
    sel_valid_o = |req_valid_i;
    if (hold_i) begin
      sel_id_o    = last_q;
      sel_valid_o = req_valid_i[last_q];
    end else if (&req_valid_i) begin
      sel_id_o = ~last_q;
    end else if (req_valid_i[1]) begin
      sel_id_o = 1'b1;
    end
  end

  // The pointer only moves when a transaction completes, so an abandoned or
  // still-pending transaction never shifts the round-robin order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (done_i) begin
      last_q <= done_id_i;
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_bus_arbiter
// Shares the single data-memory port between core 0 and core 1 with
// round-robin arbitration and exactly one transaction in flight.
// Optional feature macro: DMEM_ARB_LOCK_EN adds req_lock so a core can keep
// the bus across several transactions (LR/SC, AMO sequences).
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req_valid/req_ready          : per-core request handshake (bit i = core i)
//   req_we/addr/wdata/be         : per-core request fields, packed by core
//   req_lock (DMEM_ARB_LOCK_EN)  : per-core lock request
//   resp_valid                   : one-cycle response pulse to granted core
//   resp_rdata, resp_err         : shared response data / timeout flag
//   mem_valid/mem_ready          : request handshake toward memory
//   mem_we/addr/wdata/be         : request fields toward memory
//   mem_rvalid, mem_rdata        : memory completion and read data
// ---------------------------------------------------------------------------
module dmem_bus_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        req_valid,
  output logic [NCORES-1:0]        req_ready,
  input  logic [NCORES-1:0]        req_we,
  input  logic [NCORES*AW-1:0]     req_addr,
  input  logic [NCORES*DW-1:0]     req_wdata,
  input  logic [NCORES*(DW/8)-1:0] req_be,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NCORES-1:0]        req_lock,
`endif
  output logic [NCORES-1:0]        resp_valid,
  output logic [DW-1:0]            resp_rdata,
  output logic                     resp_err,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [DW/8-1:0]          mem_be,
  input  logic                     mem_rvalid,
  input  logic [DW-1:0]            mem_rdata
);

  localparam int BW = DW / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t        state_q;
  core_id_t          grant_q;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic [BW-1:0]     be_q;
  logic              memValid_q;
  logic [NCORES-1:0] respValid_q;
  logic              respErr_q;
  logic [DW-1:0]     respRdata_q;
  logic [CW-1:0]     waitCnt_q;

  core_id_t          selId;
  logic              selValid;
  logic              holdLast;
  logic              accept;
  logic              timeoutHit;
  logic              done;
  logic              pickWe;
  logic [AW-1:0]     pickAddr;
  logic [DW-1:0]     pickWdata;
  logic [BW-1:0]     pickBe;

`ifdef DMEM_ARB_LOCK_EN
  logic lockReq_q;
  logic locked_q;
  assign holdLast = locked_q;
`else
  assign holdLast = 1'b0;
`endif

  arb_rr_pick u_pick (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .hold_i      (holdLast),
    .done_i      (done),
    .done_id_i   (grant_q),
    .sel_id_o    (selId),
    .sel_valid_o (selValid)
  );

  assign accept = (state_q == IDLE) && selValid;

  // Timeout fires on the WAIT cycle in which the counter sits at its last
  // value with no memory response; TIMEOUT of zero never fires.
  assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q == LAST_CNT);
  assign done       = (state_q == WAIT) && (mem_rvalid || timeoutHit);

  // Ready is combinational and only ever raised for the selected core, so a
  // requester that drops valid before this point simply is not accepted.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[selId] = 1'b1;
    end
  end

  // Pull the selected core's request fields out of the packed buses.
  always_comb begin
    pickWe    = req_we[selId];
    pickAddr  = selId[0] ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
    pickWdata = selId[0] ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    pickBe    = selId[0] ? req_be[2*BW-1:BW]    : req_be[BW-1:0];
  end

  // Arbiter FSM. Every output is a register so memory sees clean, stable
  // fields while waiting for mem_ready and cores see a single-cycle response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      memValid_q  <= 1'b0;
      respValid_q <= '0;
      respErr_q   <= 1'b0;
      respRdata_q <= '0;
      waitCnt_q   <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lockReq_q   <= 1'b0;
      locked_q    <= 1'b0;
`endif
    end else begin
      respValid_q <= '0;
      respErr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            grant_q    <= selId;
            we_q       <= pickWe;
            addr_q     <= pickAddr;
            wdata_q    <= pickWdata;
            be_q       <= pickBe;
            memValid_q <= 1'b1;
`ifdef DMEM_ARB_LOCK_EN
            lockReq_q  <= req_lock[selId];
`endif
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            memValid_q <= 1'b0;
            waitCnt_q  <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          // A real response wins over a timeout landing on the same cycle.
          if (mem_rvalid) begin
            respValid_q[grant_q] <= 1'b1;
            respRdata_q          <= mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
            locked_q             <= lockReq_q;
`endif
            state_q              <= IDLE;
          end else if (timeoutHit) begin
            respValid_q[grant_q] <= 1'b1;
            respErr_q            <= 1'b1;
            respRdata_q          <= '0;
`ifdef DMEM_ARB_LOCK_EN
            locked_q             <= 1'b0;
`endif
            state_q              <= IDLE;
          end else if (waitCnt_q != '1) begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_valid  = memValid_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign resp_valid = respValid_q;
  assign resp_err   = respErr_q;
  assign resp_rdata = respRdata_q;

endmodule
